// File: rtl/sd_dma_ctrl.sv
// sd_dma_ctrl: multi-sector SD read DMA engine.
// Issues one sector request at a time to the SPI sector reader, packs the
// 16-bit words it returns into 32-bit words, buffers them in a small FIFO
// and writes them to memory through a req/ack port.
// Build option: define SD_DMA_BSWAP_EN for big-endian packing
// (first SD byte in mem_wdata[31:24]); default is little-endian.
module sd_dma_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [31:0] cfg_sec_addr,
  input  logic [15:0] cfg_sec_cnt,
  input  logic [31:0] cfg_dst_addr,
  output logic        busy,
  output logic        done,
  output logic        err_ovf,
  output logic        err_short,
  output logic        sd_start,
  output logic [31:0] sd_sec_addr,
  input  logic        sd_busy,
  input  logic        sd_val_en,
  input  logic [15:0] sd_val_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RECV,
    S_NEXT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_short_q, err_short_d;
  logic          sd_start_q, sd_start_d;
  logic [31:0]   sd_sec_addr_q, sd_sec_addr_d;   // current sector
  logic [15:0]   sec_rem_q, sec_rem_d;           // sectors still to fetch
  logic [8:0]    word_cnt_q, word_cnt_d;         // words seen in this sector
  logic [15:0]   w0_q, w0_d;                     // held even-index word
  logic          sd_busy_prev_q, sd_busy_prev_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic          push;
  logic          pop;
  logic [31:0]   push_data;

  // Pack the held even word with the incoming odd word into one memory word.
  always_comb begin
`ifdef SD_DMA_BSWAP_EN
    push_data = {w0_q, sd_val_data};
`else
    push_data = {sd_val_data[7:0], sd_val_data[15:8], w0_q[7:0], w0_q[15:8]};
`endif
  end

  // Next-state logic for the sequencer, the FIFO pointers and the memory port.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d        = state_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_ovf_d      = err_ovf_q;
    err_short_d    = err_short_q;
    sd_start_d     = sd_start_q;
    sd_sec_addr_d  = sd_sec_addr_q;
    sec_rem_d      = sec_rem_q;
    word_cnt_d     = word_cnt_q;
    w0_d           = w0_q;
    sd_busy_prev_d = sd_busy;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fifo_cnt_d     = fifo_cnt_q;
    push           = 1'b0;
    pop            = mem_req_q & mem_ack;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          sd_sec_addr_d = cfg_sec_addr;
          sec_rem_d     = cfg_sec_cnt;
          mem_addr_d    = cfg_dst_addr & 32'hFFFF_FFFC;
          err_ovf_d     = 1'b0;
          err_short_d   = 1'b0;
          busy_d        = 1'b1;
          state_d       = (cfg_sec_cnt == 16'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        sd_start_d = 1'b1;
        if (sd_busy) begin
          sd_start_d = 1'b0;
          word_cnt_d = 9'd0;
          state_d    = S_RECV;
        end
      end
      S_RECV: begin
        if (sd_val_en) begin
          word_cnt_d = word_cnt_q + 9'd1;
          if (!word_cnt_q[0]) begin
            w0_d = sd_val_data;
          end else if (!err_ovf_q) begin
            // Once an overflow hits, the rest of the sector is discarded.
            if (fifo_cnt_q == CNT_FULL && !pop) begin
              err_ovf_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end
        if (sd_busy_prev_q && !sd_busy) begin
          if (err_ovf_q) begin
            state_d = S_DRAIN;
          end else if (word_cnt_q != 9'd256) begin
            err_short_d = 1'b1;
            state_d     = S_DRAIN;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        sec_rem_d     = sec_rem_q - 16'd1;
        sd_sec_addr_d = sd_sec_addr_q + 32'd1;
        state_d       = (sec_rem_q == 16'd1) ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: begin
        if (fifo_cnt_q == '0 && !mem_req_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Memory port: load from the FIFO head while idle, hold until ack.
    if (mem_req_q) begin
      if (mem_ack) begin
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q + 32'd4;
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end
    end else if (fifo_cnt_q != '0) begin
      mem_req_d   = 1'b1;
      mem_wdata_d = fifo_mem[rd_ptr_q];
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_ONE;
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - CNT_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_ref) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_ovf_q      <= 1'b0;
      err_short_q    <= 1'b0;
      sd_start_q     <= 1'b0;
      sd_sec_addr_q  <= 32'd0;
      sec_rem_q      <= 16'd0;
      word_cnt_q     <= 9'd0;
      w0_q           <= 16'd0;
      sd_busy_prev_q <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_ovf_q      <= err_ovf_d;
      err_short_q    <= err_short_d;
      sd_start_q     <= sd_start_d;
      sd_sec_addr_q  <= sd_sec_addr_d;
      sec_rem_q      <= sec_rem_d;
      word_cnt_q     <= word_cnt_d;
      w0_q           <= w0_d;
      sd_busy_prev_q <= sd_busy_prev_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_ref) begin
    // NOTE: storage is not reset; fifo_cnt_q alone decides which entries are valid.
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_ovf     = err_ovf_q;
  assign err_short   = err_short_q;
  assign sd_start    = sd_start_q;
  assign sd_sec_addr = sd_sec_addr_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_sd_dma_ctrl.sv
// Testbench for sd_dma_ctrl: sector-reader model, memory slave with random
// ack stalls and a write scoreboard fed by the reader model.
module tb_sd_dma_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_sec_addr = '0;
  logic [15:0] cfg_sec_cnt = '0;
  logic [31:0] cfg_dst_addr = '0;
  logic        busy, done, err_ovf, err_short, sd_start, mem_req;
  logic [31:0] sd_sec_addr, mem_addr, mem_wdata;
  logic        sd_busy = 1'b0;
  logic        sd_val_en = 1'b0;
  logic [15:0] sd_val_data = '0;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad = 0;

  wr_t         exp_q[$];
  logic [31:0] sd_log[$];
  int          start_cnt = 0, write_cnt = 0, done_cnt = 0, req_cycles = 0;
  logic [31:0] last_addr = '0, last_data = '0;
  bit          ack_block = 0;
  int          max_stall = 0;
  int          rd_words = 256;
  int          rd_gap = 8;
  int          rd_idx = 0;
  bit          rd_abort = 0, rd_active = 0;
  int          sb_limit = 1000;
  int          xfer_id = 0;
  logic [31:0] exp_base = '0;
  bit          ovf_after_pair [1:128];

  sd_dma_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk_ref(clk_ref), .rst(rst),
    .cfg_start(cfg_start), .cfg_sec_addr(cfg_sec_addr),
    .cfg_sec_cnt(cfg_sec_cnt), .cfg_dst_addr(cfg_dst_addr),
    .busy(busy), .done(done), .err_ovf(err_ovf), .err_short(err_short),
    .sd_start(sd_start), .sd_sec_addr(sd_sec_addr),
    .sd_busy(sd_busy), .sd_val_en(sd_val_en), .sd_val_data(sd_val_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack)
  );

  always #5 clk_ref = ~clk_ref;

  function automatic logic [31:0] pack(input logic [15:0] a, input logic [15:0] b);
`ifdef SD_DMA_BSWAP_EN
    return {a, b};
`else
    return {b[7:0], b[15:8], a[7:0], a[15:8]};
`endif
  endfunction

  // Sector reader model: answers each sd_start with busy, words, busy drop,
  // and pushes the expected packed writes into the scoreboard.
  initial begin : reader
    int          seen_id = 0;
    int          pairs;
    logic [15:0] w0;
    logic [15:0] word_ctr;
    logic [31:0] exp_addr;
    int          sb_pushed;
    w0 = '0; word_ctr = 16'h0001; exp_addr = '0; sb_pushed = 0;
    forever begin
      @(negedge clk_ref);
      if (sd_start && !rd_abort) begin
        if (seen_id != xfer_id) begin
          seen_id = xfer_id; exp_addr = exp_base; sb_pushed = 0; word_ctr = 16'h0001;
        end
        sd_log.push_back(sd_sec_addr);
        start_cnt++;
        rd_active = 1;
        rd_idx = 0;
        repeat (2) @(negedge clk_ref);
        sd_busy = 1'b1;
        repeat (2) @(negedge clk_ref);
        pairs = 0;
        for (int i = 0; i < rd_words && !rd_abort; i++) begin
          rd_idx = i;
          sd_val_en = 1'b1;
          sd_val_data = word_ctr;
          if ((i % 2) == 0) begin
            w0 = word_ctr;
          end else begin
            pairs++;
            if (sb_pushed < sb_limit) begin
              exp_q.push_back({exp_addr, pack(w0, word_ctr)});
              exp_addr = exp_addr + 32'd4;
              sb_pushed++;
            end
          end
          word_ctr = word_ctr + 16'd1;
          @(negedge clk_ref);
          sd_val_en = 1'b0;
          if ((i % 2) == 1 && pairs <= 128) ovf_after_pair[pairs] = err_ovf;
          repeat (rd_gap - 1) @(negedge clk_ref);
        end
        sd_busy = 1'b0;
        if (rd_abort) exp_q.delete();
        rd_active = 0;
      end
    end
  end

  // Memory slave and scoreboard checker; also counts done pulses.
  initial begin : mem_mon
    int  stall_left = 0;
    bit  armed = 0;
    wr_t e;
    forever begin
      @(negedge clk_ref);
      if (done) done_cnt++;
      if (mem_req) req_cycles++;
      mem_ack = 1'b0;
      if (!mem_req) begin
        armed = 0;
      end else if (!ack_block) begin
        if (!armed) begin
          stall_left = int'($urandom_range(0, max_stall));
          armed = 1;
        end
        if (stall_left == 0) begin
          mem_ack = 1'b1;
          armed = 0;
          write_cnt++;
          last_addr = mem_addr;
          last_data = mem_wdata;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL mem_write unexpected: addr=%h data=%h", mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
              bad++;
              $display("FAIL mem_write got addr=%h data=%h, want addr=%h data=%h",
                       mem_addr, mem_wdata, e.addr, e.data);
            end
          end
        end else begin
          stall_left--;
        end
      end
    end
  end

  task automatic start_xfer(input logic [31:0] sec, input logic [15:0] cnt, input logic [31:0] dst);
    exp_base = dst & 32'hFFFF_FFFC;
    xfer_id++;
    @(negedge clk_ref);
    cfg_sec_addr = sec; cfg_sec_cnt = cnt; cfg_dst_addr = dst; cfg_start = 1'b1;
    @(negedge clk_ref);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, input string name);
    int n = 0;
    while (done_cnt == base && n < bound) begin
      @(negedge clk_ref);
      n++;
    end
    total++;
    if (done_cnt == base) begin
      bad++;
      $display("FAIL %s done_timeout after %0d cycles", name, n);
    end
    repeat (5) @(negedge clk_ref);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_ref);
    total++;
    if ({busy, done, err_ovf, err_short, sd_start, sd_sec_addr, mem_req, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs busy=%b done=%b ovf=%b short=%b start=%b sec=%h req=%b addr=%h data=%h",
               busy, done, err_ovf, err_short, sd_start, sd_sec_addr, mem_req, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk_ref);
    total++;
    if ({busy, sd_start, mem_req} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b start=%b req=%b, want 000", busy, sd_start, mem_req);
    end
  endtask

  task automatic test_single();
    int d0 = done_cnt, w0 = write_cnt, s0 = start_cnt, n = 0;
    max_stall = 0; ack_block = 0; rd_words = 256; sb_limit = 1000;
    start_xfer(32'h100, 16'd1, 32'h8000_0000);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_rise got=%b want=1", busy); end
    while (write_cnt == w0 && n < 2000) begin @(negedge clk_ref); n++; end
    total++;
    if (last_addr !== 32'h8000_0000) begin bad++; $display("FAIL single_first_addr got=%h want=80000000", last_addr); end
    total++;
`ifdef SD_DMA_BSWAP_EN
    if (last_data !== 32'h0001_0002) begin bad++; $display("FAIL single_first_data got=%h want=00010002", last_data); end
`else
    if (last_data !== 32'h0200_0100) begin bad++; $display("FAIL single_first_data got=%h want=02000100", last_data); end
`endif
    wait_done(d0, 10000, "single");
    total++;
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_starts got=%0d want=1", start_cnt - s0); end
    total++;
    if (sd_log[s0] !== 32'h100) begin bad++; $display("FAIL single_sec_addr got=%h want=100", sd_log[s0]); end
    total++;
    if (write_cnt - w0 != 128) begin bad++; $display("FAIL single_writes got=%0d want=128", write_cnt - w0); end
    total++;
    if (last_addr !== 32'h8000_01FC) begin bad++; $display("FAIL single_last_addr got=%h want=800001fc", last_addr); end
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done_pulses got=%0d want=1", done_cnt - d0); end
    total++;
    if ({busy, err_ovf, err_short} !== 3'b000) begin
      bad++; $display("FAIL single_flags busy/ovf/short got=%b%b%b want=000", busy, err_ovf, err_short);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL single_sb_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_multi();
    int d0 = done_cnt, w0 = write_cnt, s0 = start_cnt;
    max_stall = 6; ack_block = 0; rd_words = 256; sb_limit = 1000;
    start_xfer(32'h20, 16'd3, 32'h0000_1000);
    repeat (100) @(negedge clk_ref);
    cfg_sec_addr = 32'h999; cfg_sec_cnt = 16'd1; cfg_dst_addr = 32'h7000; cfg_start = 1'b1;
    @(negedge clk_ref);
    cfg_start = 1'b0;
    wait_done(d0, 30000, "multi");
    total++;
    if (start_cnt - s0 != 3) begin bad++; $display("FAIL multi_starts got=%0d want=3", start_cnt - s0); end
    for (int k = 0; k < 3 && s0 + k < sd_log.size(); k++) begin
      total++;
      if (sd_log[s0 + k] !== 32'h20 + 32'(k)) begin
        bad++; $display("FAIL multi_sec_addr[%0d] got=%h want=%h", k, sd_log[s0 + k], 32'h20 + 32'(k));
      end
    end
    total++;
    if (write_cnt - w0 != 384) begin bad++; $display("FAIL multi_writes got=%0d want=384", write_cnt - w0); end
    total++;
    if (last_addr !== 32'h0000_15FC) begin bad++; $display("FAIL multi_last_addr got=%h want=000015fc", last_addr); end
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL multi_done_pulses got=%0d want=1", done_cnt - d0); end
    total++;
    if ({err_ovf, err_short} !== 2'b00) begin bad++; $display("FAIL multi_errs got=%b%b want=00", err_ovf, err_short); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL multi_sb_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_zero_cnt();
    int d0 = done_cnt, s0 = start_cnt, r0 = req_cycles;
    @(negedge clk_ref);
    cfg_sec_addr = 32'h55; cfg_sec_cnt = 16'd0; cfg_dst_addr = 32'h9000; cfg_start = 1'b1;
    @(negedge clk_ref);
    cfg_start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10) begin bad++; $display("FAIL zero_cycle1 busy/done got=%b%b want=10", busy, done); end
    @(negedge clk_ref);
    total++;
    if ({busy, done} !== 2'b01) begin bad++; $display("FAIL zero_cycle2 busy/done got=%b%b want=01", busy, done); end
    repeat (4) @(negedge clk_ref);
    total++;
    if (start_cnt != s0 || req_cycles != r0 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL zero_side_effects starts=%0d reqs=%0d dones=%0d want 0 0 1",
               start_cnt - s0, req_cycles - r0, done_cnt - d0);
    end
  endtask

  task automatic test_overflow();
    int d0 = done_cnt, w0 = write_cnt, s0 = start_cnt, n = 0;
    ack_block = 1; max_stall = 0; rd_words = 256; sb_limit = 8;
    start_xfer(32'h40, 16'd2, 32'h2000_0000);
    while (!(start_cnt > s0 && !rd_active) && n < 5000) begin @(negedge clk_ref); n++; end
    repeat (50) @(negedge clk_ref);
    total++;
    if (ovf_after_pair[8] !== 1'b0) begin bad++; $display("FAIL ovf_after_8 got=%b want=0", ovf_after_pair[8]); end
    total++;
    if (ovf_after_pair[9] !== 1'b1) begin bad++; $display("FAIL ovf_after_9 got=%b want=1", ovf_after_pair[9]); end
    total++;
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL ovf_starts got=%0d want=1", start_cnt - s0); end
    total++;
    if (done_cnt != d0 || mem_req !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL ovf_stalled dones=%0d req=%b busy=%b want 0 1 1", done_cnt - d0, mem_req, busy);
    end
    ack_block = 0;
    wait_done(d0, 2000, "overflow");
    total++;
    if (write_cnt - w0 != 8) begin bad++; $display("FAIL ovf_writes got=%0d want=8", write_cnt - w0); end
    total++;
    if ({err_ovf, err_short} !== 2'b10) begin bad++; $display("FAIL ovf_errs got=%b%b want=10", err_ovf, err_short); end
    total++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL ovf_end dones=%0d sb_left=%0d want 1 0", done_cnt - d0, exp_q.size());
    end
    sb_limit = 1000;
  endtask

  task automatic test_short();
    int d0 = done_cnt, w0 = write_cnt, s0 = start_cnt;
    ack_block = 0; max_stall = 2; rd_words = 200; sb_limit = 1000;
    start_xfer(32'h60, 16'd3, 32'h0000_3000);
    wait_done(d0, 10000, "short");
    repeat (100) @(negedge clk_ref);
    total++;
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL short_starts got=%0d want=1", start_cnt - s0); end
    total++;
    if (write_cnt - w0 != 100) begin bad++; $display("FAIL short_writes got=%0d want=100", write_cnt - w0); end
    total++;
    if ({err_ovf, err_short} !== 2'b01) begin bad++; $display("FAIL short_errs got=%b%b want=01", err_ovf, err_short); end
    total++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL short_end dones=%0d sb_left=%0d want 1 0", done_cnt - d0, exp_q.size());
    end
    rd_words = 256;
  endtask

  task automatic test_rst_mid();
    int d0 = done_cnt, n = 0, d1, w1, s1;
    max_stall = 0; ack_block = 0; rd_words = 256;
    start_xfer(32'h80, 16'd1, 32'h0000_4000);
    while (!(rd_active && rd_idx >= 40) && n < 3000) begin @(negedge clk_ref); n++; end
    rst = 1'b1;
    rd_abort = 1;
    @(negedge clk_ref);
    total++;
    if ({busy, done, err_ovf, err_short, sd_start, sd_sec_addr, mem_req, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs busy=%b done=%b start=%b sec=%h req=%b addr=%h data=%h",
               busy, done, sd_start, sd_sec_addr, mem_req, mem_addr, mem_wdata);
    end
    @(negedge clk_ref);
    rst = 1'b0;
    n = 0;
    while (rd_active && n < 100) begin @(negedge clk_ref); n++; end
    rd_abort = 0;
    repeat (20) @(negedge clk_ref);
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", done_cnt - d0); end
    d1 = done_cnt; w1 = write_cnt; s1 = start_cnt;
    start_xfer(32'h90, 16'd1, 32'h0000_5000);
    wait_done(d1, 10000, "rst_recover");
    total++;
    if (write_cnt - w1 != 128 || last_addr !== 32'h0000_51FC) begin
      bad++; $display("FAIL rst_recover_writes got=%0d last=%h want 128 000051fc", write_cnt - w1, last_addr);
    end
    total++;
    if (start_cnt - s1 != 1 || sd_log[sd_log.size() - 1] !== 32'h90) begin
      bad++; $display("FAIL rst_recover_sector starts=%0d sec=%h want 1 90", start_cnt - s1, sd_log[sd_log.size() - 1]);
    end
    total++;
    if ({err_ovf, err_short} !== 2'b00 || done_cnt - d1 != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL rst_recover_end errs=%b%b dones=%0d sb_left=%0d want 00 1 0",
                      err_ovf, err_short, done_cnt - d1, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero_cnt();
    test_overflow();
    test_short();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_dma_ctrl.md
# sd_dma_ctrl

Multi-sector SD read DMA engine placed directly downstream of the SD-card SPI sector reader. It issues one CMD17 request per sector through the reader's start/address/busy interface and collects the 256 16-bit words the reader produces per sector. It packs those words into 32-bit memory words, buffers them in a small FIFO, and writes them to system memory through a req/ack write port. Software programs the source sector, the sector count and the destination address, pulses start, and waits for done.

## Interface
- FIFO_DEPTH, 8, depth of the 32-bit packing FIFO; power of two, minimum 2
- clk_ref  in  1  system clock; same clock as the sector reader
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle pulse that starts a transfer; ignored while busy=1
- cfg_sec_addr  in  32  first SD sector address; sampled on cfg_start
- cfg_sec_cnt  in  16  number of sectors; sampled on cfg_start
- cfg_dst_addr  in  32  destination byte address; 4-byte aligned, bits [1:0] ignored
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer ends, normally or on error
- err_ovf  out  1  sticky: FIFO overflow; cleared on the next accepted cfg_start
- err_short  out  1  sticky: a sector delivered a word count other than 256; cleared on the next accepted cfg_start
- sd_start  out  1  start request to the sector reader (level)
- sd_sec_addr  out  32  sector address for the sector reader
- sd_busy  in  1  sector reader busy flag
- sd_val_en  in  1  one-cycle valid pulse for sd_val_data
- sd_val_data  in  16  16-bit read data word; first SD byte in [15:8]
- mem_req  out  1  memory write request; held until mem_ack
- mem_addr  out  32  memory write byte address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  write accepted in this cycle

## Operation
- State machine: IDLE, ISSUE, RECV, NEXT, DRAIN, DONE.
- IDLE
  - On cfg_start, latch the three cfg inputs, clear both error flags and set busy.
  - If cfg_sec_cnt=0, go to DONE. Otherwise go to ISSUE.
- ISSUE
  - Drive sd_start=1 and sd_sec_addr = current sector.
  - When sd_busy=1 is seen, drop sd_start, clear the word counter and go to RECV.
- RECV
  - Each sd_val_en pulse increments a 9-bit word counter.
  - Even-index words are held. Each odd-index word completes a 32-bit word, which is pushed to the FIFO.
- Packing, default: mem_wdata = {w1[7:0], w1[15:8], w0[7:0], w0[15:8]}, i.e. little-endian, with the first SD byte at [7:0].
- Exit from RECV on the sd_busy 1->0 transition:
  - If the word count is not 256, set err_short and go to DRAIN.
  - Otherwise go to NEXT.
- NEXT
  - Decrement the remaining-sector count and increment the current sector by 1.
  - If the remaining count is now 0, go to DRAIN. Otherwise go to ISSUE.
  - sd_start is low for at least one cycle between sectors, so the reader's edge detector fires.
- Overflow: a push while the FIFO is full sets err_ovf and drops the word. Remaining sd_val_en pulses in that sector are discarded. After the current sd_busy falls, go to DRAIN; no further sectors are issued.
- DRAIN: wait until the FIFO is empty and no mem_req is outstanding, then go to DONE.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- Memory port
  - mem_req/mem_addr/mem_wdata are registered from the FIFO head. Address and data stay stable while mem_req=1.
  - On mem_ack, pop the FIFO and add 4 to mem_addr (32-bit wrap).
  - mem_req may drop for one cycle between writes, or stay high back-to-back when the FIFO is non-empty.
- A push and a pop in the same cycle on a full FIFO is legal and not an overflow.

## Timing
- Reset values: busy=0, done=0, err_ovf=0, err_short=0, sd_start=0, sd_sec_addr=0, mem_req=0, mem_addr=0, mem_wdata=0; FSM in IDLE; FIFO empty.
- A rst asserted mid-transfer aborts immediately: all outputs return to reset values on the next edge and no done pulse is generated.
- busy rises the cycle after cfg_start. cfg_start while busy=1 has no effect.
- sd_start rises the cycle after entry to ISSUE and falls the cycle after sd_busy=1 is sampled.
- A word is pushed to the FIFO the cycle after its second sd_val_en pulse. mem_req rises at the earliest one cycle after the FIFO becomes non-empty.
- done is asserted in the cycle after DRAIN completes; busy falls in the same cycle.
- sd_val_en pulses are assumed at least 2 cycles apart (the reader yields one word per 16 clocks). The FIFO therefore tolerates up to 8 cycles of mem_ack stall per word without overflow at depth 8.

## Configuration
- SD_DMA_BSWAP_EN defined: big-endian packing, mem_wdata = {w0, w1}, with the first SD byte at [31:24].
- SD_DMA_BSWAP_EN undefined: little-endian packing, as in Operation.

## Test plan
- Single sector: sec_addr=0x100, cnt=1, dst=0x8000_0000, words 0x0001..0x0100, mem_ack always 1.
  - sd_start pulses once with sd_sec_addr=0x100.
  - 128 writes, the first being addr 0x8000_0000, data 0x0200_0100 (little-endian packing of the 0x0001, 0x0002 word pair).
  - The last write is to addr 0x8000_01FC. One done pulse, both error flags 0.
- Three sectors from 0x20 with mem_ack randomly stalled up to 6 cycles.
  - sd_sec_addr takes 0x20, 0x21, 0x22.
  - 384 writes at contiguous addresses, one done pulse, no errors.
- cnt=0: done pulses 2 cycles after cfg_start, with no sd_start and no mem_req.
- mem_ack held at 0 for a full sector.
  - err_ovf=1 after the 9th packed word.
  - No second sd_start; the FIFO drains once mem_ack is released; done pulses.
- Reader returns 200 words and then drops sd_busy: err_short=1, remaining sectors are skipped, 100 writes are issued, done pulses.
- rst pulsed mid-RECV: all outputs go to reset values the next cycle. A following cfg_start runs a clean one-sector transfer.
